// File: rtl/div32_seq.sv
// ---------------------------------------------------------------------------
// div32_seq : 32-bit sequential restoring divider, signed or unsigned.
//
// Timing: a START taken in IDLE loads the operands (edge 0). Edges 1..32 each
// run one shift-subtract iteration, MSB first. Edge 33 applies the sign fixup,
// registers HI/LO/DIVZ and pulses DONE. Latency is fixed for all operands,
// including a zero divisor.
//
// Ports:
//   CLK     input   1   rising-edge clock
//   RST     input   1   asynchronous active-low reset
//   START   input   1   request a division; only sampled while idle
//   SIGNED  input   1   1 = two's-complement divide, 0 = unsigned
//   A       input  32   dividend, sampled with START
//   B       input  32   divisor, sampled with START
//   HI      output 32   remainder (sign follows the dividend)
//   LO      output 32   quotient (truncated toward zero)
//   BUSY    output  1   operation in progress
//   DONE    output  1   one-cycle pulse when HI/LO are updated
//   DIVZ    output  1   last completed operation had B == 0
// ---------------------------------------------------------------------------
module div32_seq (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic        SIGNED,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        BUSY,
   output logic        DONE,
   output logic        DIVZ
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state;
   logic        [4:0]  cnt;

   // Operand and working registers; they carry no reset because every
   // operation reloads them before use.
   logic        [32:0] rem;
   logic        [31:0] quo;
   logic        [31:0] dmag;
   logic signed [31:0] a_lat;
   logic               sgn_lat;
   logic               a_neg;
   logic               b_neg;
   logic               divz_lat;

   logic        [32:0] rem_sh;
   logic        [32:0] rem_try;
   logic        [31:0] q_fix;
   logic        [31:0] r_fix;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   // Magnitude of an operand; in unsigned mode the value passes untouched.
   // 0x80000000 maps to itself, which is the correct unsigned magnitude.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic s);
      return (s && v[31]) ? neg32(v) : v;
   endfunction

   // One restoring step: shift the next dividend bit in, trial-subtract.
   always_comb begin
      rem_sh  = {rem[31:0], quo[31]};
      rem_try = rem_sh - {1'b0, dmag};
   end

   // Sign fixup. The overflow case 0x80000000 / -1 has equal signs, so the
   // quotient magnitude 0x80000000 is passed through unnegated.
   always_comb begin
      q_fix = quo;
      r_fix = rem[31:0];
      if (sgn_lat && (a_neg ^ b_neg))
         q_fix = neg32(quo);
      if (sgn_lat && a_neg)
         r_fix = neg32(rem[31:0]);
   end

   // ---- load / iterate stage ----
   always_ff @(posedge CLK) begin
      case (state)
         IDLE: begin
            if (START) begin
               sgn_lat  <= SIGNED;
               a_lat    <= A;
               a_neg    <= A[31];
               b_neg    <= B[31];
               divz_lat <= (B == 32'd0);
               dmag     <= mag32(B, SIGNED);
               quo      <= mag32(A, SIGNED);
               rem      <= '0;
            end
         end
         CALC: begin
            // Quotient bit is 1 when the trial subtraction did not borrow.
            quo <= {quo[30:0], ~rem_try[32]};
            rem <= rem_try[32] ? rem_sh : rem_try;
         end
         default: ;
      endcase
   end

   // ---- control and result stage ----
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
         cnt   <= '0;
         HI    <= '0;
         LO    <= '0;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
         DIVZ  <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  cnt   <= '0;
                  BUSY  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31)
                  state <= FIX;
            end
            FIX: begin
               // Zero divisor: report all-ones quotient and the raw dividend.
               LO    <= divz_lat ? 32'hFFFF_FFFF : q_fix;
               HI    <= divz_lat ? a_lat : r_fix;
               DIVZ  <= divz_lat;
               DONE  <= 1'b1;
               BUSY  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div32_seq.sv
// ---------------------------------------------------------------------------
// tb_div32_seq : directed self-checking bench for div32_seq.
// ---------------------------------------------------------------------------
module tb_div32_seq;

   logic        CLK;
   logic        RST;
   logic        START;
   logic        SIGNED;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        BUSY;
   logic        DONE;
   logic        DIVZ;

   int checks = 0;
   int errors = 0;

   div32_seq dut (
      .CLK    (CLK),
      .RST    (RST),
      .START  (START),
      .SIGNED (SIGNED),
      .A      (A),
      .B      (B),
      .HI     (HI),
      .LO     (LO),
      .BUSY   (BUSY),
      .DONE   (DONE),
      .DIVZ   (DIVZ)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_hi"},   HI,   32'd0);
      check({tag, "_lo"},   LO,   32'd0);
      check({tag, "_busy"}, BUSY, 32'd0);
      check({tag, "_done"}, DONE, 32'd0);
      check({tag, "_divz"}, DIVZ, 32'd0);
   endtask

   // Present an operation and take it on the next rising edge (edge 0).
   // With rel set, reset is released on the same falling edge.
   task automatic start_op(input string tag, input logic rel, input logic s,
                           input logic [31:0] a, input logic [31:0] b);
      @(negedge CLK);
      if (rel) RST = 1'b1;
      SIGNED = s;
      A      = a;
      B      = b;
      START  = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      check({tag, "_busy0"}, BUSY, 32'd1);
      check({tag, "_done0"}, DONE, 32'd0);
   endtask

   // n = edges still to go before edge 32; edge 33 follows.
   task automatic expect_done(input string tag, input int n, input logic [31:0] lo,
                              input logic [31:0] hi, input logic dz);
      repeat (n) @(posedge CLK);
      #1;
      check({tag, "_busy32"}, BUSY, 32'd1);
      check({tag, "_done32"}, DONE, 32'd0);
      @(posedge CLK);
      #1;
      check({tag, "_done"}, DONE, 32'd1);
      check({tag, "_busy"}, BUSY, 32'd0);
      check({tag, "_lo"},   LO,   lo);
      check({tag, "_hi"},   HI,   hi);
      check({tag, "_divz"}, DIVZ, {31'd0, dz});
   endtask

   initial begin
      RST    = 1'b0;
      START  = 1'b0;
      SIGNED = 1'b0;
      A      = 32'd0;
      B      = 32'd0;
      repeat (3) @(posedge CLK);
      #1;
      check_zero("reset");

      // START on the first edge after release; 100 / 7 = 14 r 2
      start_op("u100_7", 1'b1, 1'b0, 32'd100, 32'd7);
      expect_done("u100_7", 32, 32'd14, 32'd2, 1'b0);
      @(posedge CLK);
      #1;
      check("u100_7_pulse", DONE, 32'd0);
      check("u100_7_hold_lo", LO, 32'd14);
      check("u100_7_hold_hi", HI, 32'd2);

      // -7 / 2 = -3 r -1 ; 7 / -2 = -3 r 1
      start_op("s_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
      expect_done("s_m7_2", 32, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      start_op("s_7_m2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);
      expect_done("s_7_m2", 32, 32'hFFFF_FFFD, 32'd1, 1'b0);

      // Divide by zero, both modes; HI is the raw dividend
      start_op("u_divz", 1'b0, 1'b0, 32'h1234_5678, 32'd0);
      expect_done("u_divz", 32, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
      start_op("s_divz", 1'b0, 1'b1, 32'h8765_4321, 32'd0);
      expect_done("s_divz", 32, 32'hFFFF_FFFF, 32'h8765_4321, 1'b1);

      // Signed overflow and unsigned max
      start_op("s_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      expect_done("s_ovf", 32, 32'h8000_0000, 32'd0, 1'b0);
      start_op("u_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
      expect_done("u_max", 32, 32'hFFFF_FFFF, 32'd0, 1'b0);

      // Unsigned never negates: 4294967289 / 2 = 2147483644 r 1
      start_op("u_noneg", 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2);
      expect_done("u_noneg", 32, 32'h7FFF_FFFC, 32'd1, 1'b0);

      // Second START with new operands at edge 10 is ignored
      start_op("ign", 1'b0, 1'b0, 32'd100, 32'd7);
      repeat (9) @(posedge CLK);
      @(negedge CLK);
      SIGNED = 1'b1;
      A      = 32'd5;
      B      = 32'd3;
      START  = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      expect_done("ign", 22, 32'd14, 32'd2, 1'b0);

      // START held in the DONE cycle launches the next op: 1000 / 33 = 30 r 10
      SIGNED = 1'b0;
      A      = 32'd1000;
      B      = 32'd33;
      START  = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      check("b2b_done0", DONE, 32'd0);
      check("b2b_busy0", BUSY, 32'd1);
      expect_done("b2b", 32, 32'd30, 32'd10, 1'b0);

      // Asynchronous reset in the middle of an operation
      start_op("abort", 1'b0, 1'b0, 32'd100, 32'd7);
      repeat (14) @(posedge CLK);
      @(negedge CLK);
      #1;
      RST = 1'b0;
      #1;
      check_zero("async_rst");
      repeat (40) @(posedge CLK);
      #1;
      check_zero("rst_held");

      start_op("post_rst", 1'b1, 1'b0, 32'd100, 32'd7);
      expect_done("post_rst", 32, 32'd14, 32'd2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
